// File: rtl/mult_booth4.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier, WIDTH/2 cycles.
// Optional feature macro: MULT_OVF_EN (registers a signed-WIDTH overflow flag).
module mult_booth4 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] out,
    output logic               result_rdy,
    output logic               busy,
    output logic               overflow
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = 2 * WIDTH + 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_reg;
    logic [PW-1:0]    p, p_nxt;
    logic [WIDTH+1:0] a_ext, addend, sum;
    logic             cin, last, load;

    assign a_ext = {{2{a_reg[WIDTH-1]}}, a_reg};
    assign last  = (counter == CW'(ITER - 1));
    assign load  = start && (state == IDLE || state == DONE);

    always_comb begin
        addend = '0;
        cin    = 1'b0;
        unique case (p[2:0])
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_ext << 1;
            3'b100: begin
                addend = ~(a_ext << 1);
                cin    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = ~a_ext;
                cin    = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator field carries two guard bits so 2A of the most-negative A fits
    assign sum   = p[PW-1:WIDTH+1] + addend + {{(WIDTH+1){1'b0}}, cin};
    assign p_nxt = $signed({sum, p[WIDTH:0]}) >>> 2;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            a_reg   <= '0;
            p       <= '0;
            out     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg   <= multiplicand;
                p       <= {{(WIDTH+2){1'b0}}, multiplier, 1'b0};
                counter <= '0;
            end else if (state == RUN) begin
                p       <= p_nxt;
                counter <= counter + CW'(1);
                if (last) out <= p_nxt[2*WIDTH:1];
            end
        end
    end

    assign result_rdy = (state == DONE);
    assign busy       = (state != IDLE);

`ifdef MULT_OVF_EN
    logic [WIDTH:0] top;
    logic           ovf_q;

    assign top = p_nxt[2*WIDTH:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last && !load) begin
            ovf_q <= !((&top) || (~|top));
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth4.sv
// Scoreboard bench for mult_booth4: directed corner cases plus random operands
// checked against plain signed arithmetic.
module tb_mult_booth4;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [2*W-1:0] out;
    logic           result_rdy, busy, overflow;

    mult_booth4 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .out(out), .result_rdy(result_rdy), .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        logic        ovf;
        int          cyc0;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int c0);
        exp_t   e;
        longint pr;
        pr     = longint'($signed(a)) * longint'($signed(b));
        e.prod = pr;
`ifdef MULT_OVF_EN
        e.ovf  = (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
`else
        e.ovf  = 1'b0;
`endif
        e.cyc0 = c0;
        return e;
    endfunction

    // Monitor: pops on every result_rdy, then checks the strobe drops and out holds
    logic        chk_next = 1'b0;
    logic [63:0] last_out;

    always @(negedge clk) begin
        if (!reset) begin
            if (chk_next) begin
                check("rdy_one_cycle", {63'd0, result_rdy}, 64'd0);
                check("out_hold", out, last_out);
                chk_next = 1'b0;
            end
            if (result_rdy) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rdy: got out 0x%0h expected none",
                             out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("product", out, e.prod);
                    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                    check("latency", 64'(cyc - e.cyc0), 64'd16);
                    last_out = out;
                    chk_next = 1'b1;
                end
            end
        end
    end

    // All tasks are entered just after a negedge and return just after one
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit accepted);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        if (accepted) q.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!result_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!result_rdy) begin
            tests++;
            fails++;
            $display("FAIL rdy_timeout: got no result_rdy expected one");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy || q.size() != 0) begin
            fails++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected 0",
                     busy, q.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        unique case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", out, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rdy", {63'd0, result_rdy}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        start_op(32'd3, 32'd5, 1'b1);
        check("busy_run", {63'd0, busy}, 64'd1);
        wait_idle();
        start_op(32'hFFFF_FFF9, 32'd6, 1'b1);
        wait_idle();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_idle();
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        start_op(32'd2, 32'd3, 1'b1);
        repeat (4) @(negedge clk);
        start_op(32'd9, 32'd9, 1'b0);
        wait_idle();

        start_op(32'd5, 32'd7, 1'b1);
        wait_rdy();
        start_op(32'hFFFF_FFFF, 32'd4, 1'b1);
        wait_idle();

        start_op(32'd100, 32'd100, 1'b1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_out", out, 64'h0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_rdy", {63'd0, result_rdy}, 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        start_op(32'd100, 32'd100, 1'b1);
        wait_idle();
        check("after_abort", out, 64'h2710);

        for (int i = 0; i < 40; i++) begin
            start_op(pick(), pick(), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat (3) @(negedge clk);
                start_op(pick(), pick(), 1'b0);
            end
            wait_rdy();
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
